// File: rtl/qpsk_frame_scheduler.sv
// rtl/qpsk_frame_scheduler.sv - QPSK frame sequencer: preamble, payload, gap symbols
// with a fixed SPS-clock symbol cadence and a valid/ready payload pull.
module qpsk_frame_scheduler #(
  parameter int SPS           = 8,
  parameter int PREAMBLE_SYMS = 16,
  parameter int PAYLOAD_SYMS  = 64,
  parameter int GAP_SYMS      = 8,
  parameter int CNT_W         = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       START,
  input  logic       CONTINUOUS,
  input  logic       BIT_VALID,
  input  logic [1:0] BIT_DATA,
  output logic       BIT_READY,
  output logic       SYM_STROBE,
  output logic [1:0] SYM_DIBIT,
  output logic       SYM_ZERO,
  output logic       BUSY,
  output logic       UNDERFLOW
);

  localparam int SAMP_W = $clog2(SPS);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPS - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PREAMBLE_SYMS - 1);
  localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(PAYLOAD_SYMS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_SYMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              strobe_q, strobe_d;
  logic [1:0]        dibit_q, dibit_d;
  logic              zero_q, zero_d;
  logic              underflow_q, underflow_d;
  logic              boundary;
  logic              ready;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      samp_q      <= '0;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      dibit_q     <= 2'b00;
      zero_q      <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
      dibit_q     <= dibit_d;
      zero_q      <= zero_d;
      underflow_q <= underflow_d;
    end
  end

  // Every decision is taken on the boundary cycle and lands, registered, on the strobe cycle.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    cnt_d       = cnt_q;
    strobe_d    = 1'b0;
    dibit_d     = dibit_q;
    zero_d      = zero_q;
    underflow_d = underflow_q;
    ready       = 1'b0;
    boundary    = (state_q != S_IDLE) && (samp_q == SAMP_LAST);
    if (state_q == S_IDLE) begin
      if (START) begin
        state_d  = S_PRE;
        samp_d   = '0;
        cnt_d    = '0;
        strobe_d = 1'b1;
        dibit_d  = 2'b00;
        zero_d   = 1'b0;
      end
    end else begin
      samp_d = boundary ? '0 : samp_q + 1'b1;
      if (boundary) begin
        strobe_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        case (state_q)
          S_PRE: begin
            if (cnt_q == PRE_LAST) begin
              state_d = S_PAY;
              cnt_d   = '0;
              ready   = 1'b1;
            end else begin
              dibit_d = cnt_q[0] ? 2'b00 : 2'b11;
              zero_d  = 1'b0;
            end
          end
          S_PAY: begin
            if (cnt_q == PAY_LAST) begin
              state_d = S_GAP;
              cnt_d   = '0;
              dibit_d = 2'b00;
              zero_d  = 1'b1;
            end else begin
              ready = 1'b1;
            end
          end
          S_GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              dibit_d = 2'b00;
              if (CONTINUOUS) begin
                state_d = S_PRE;
                zero_d  = 1'b0;
              end else begin
                state_d  = S_IDLE;
                strobe_d = 1'b0;
                zero_d   = 1'b1;
              end
            end
          end
          default: ;
        endcase
        // A missing dibit never stretches the slot: send 00 and flag it.
        if (ready) begin
          zero_d = 1'b0;
          if (BIT_VALID) begin
            dibit_d = BIT_DATA;
          end else begin
            dibit_d     = 2'b00;
            underflow_d = 1'b1;
          end
        end
      end
    end
  end

  assign BIT_READY  = ready;
  assign SYM_STROBE = strobe_q;
  assign SYM_DIBIT  = dibit_q;
  assign SYM_ZERO   = zero_q;
  assign BUSY       = (state_q != S_IDLE);
  assign UNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// tb/tb_qpsk_frame_scheduler.sv - scoreboard bench for qpsk_frame_scheduler
// (SPS=8, 4/4/2 symbol frames, plus an SPS=2 1/1/1 instance).
module tb_qpsk_frame_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cont, bit_valid;
  logic [1:0] bit_data;
  logic       bit_ready, sym_strobe, sym_zero, busy, underflow;
  logic [1:0] sym_dibit;

  logic       start2;
  logic       bit_ready2, sym_strobe2, sym_zero2, busy2, underflow2;
  logic [1:0] sym_dibit2;

  qpsk_frame_scheduler #(.SPS(8), .PREAMBLE_SYMS(4), .PAYLOAD_SYMS(4), .GAP_SYMS(2), .CNT_W(8)) dut (
    .CLOCK_50(clk), .RESET(rst), .START(start), .CONTINUOUS(cont),
    .BIT_VALID(bit_valid), .BIT_DATA(bit_data), .BIT_READY(bit_ready),
    .SYM_STROBE(sym_strobe), .SYM_DIBIT(sym_dibit), .SYM_ZERO(sym_zero),
    .BUSY(busy), .UNDERFLOW(underflow)
  );

  qpsk_frame_scheduler #(.SPS(2), .PREAMBLE_SYMS(1), .PAYLOAD_SYMS(1), .GAP_SYMS(1), .CNT_W(8)) dut2 (
    .CLOCK_50(clk), .RESET(rst), .START(start2), .CONTINUOUS(1'b0),
    .BIT_VALID(1'b1), .BIT_DATA(2'b10), .BIT_READY(bit_ready2),
    .SYM_STROBE(sym_strobe2), .SYM_DIBIT(sym_dibit2), .SYM_ZERO(sym_zero2),
    .BUSY(busy2), .UNDERFLOW(underflow2)
  );

  typedef struct {
    int         c;
    logic [1:0] d;
    logic       z;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] src_dat[8];
  logic       src_val[8];
  int         src_idx = 0;

  always @(posedge clk) cyc++;

  // Bit source: presents the next slot's dibit whenever the DUT asks for one.
  always @(negedge clk) begin
    if (bit_ready === 1'b1) begin
      bit_data  = src_dat[src_idx % 8];
      bit_valid = src_val[src_idx % 8];
      src_idx++;
    end
  end

  // Scoreboard: each strobe must match the oldest expected symbol.
  always @(negedge clk) begin
    if (sym_strobe !== 1'b0) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: strobe=%b at cyc=%0d, required none", sym_strobe, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.c || sym_dibit !== e.d || sym_zero !== e.z) begin
          n_err++;
          $display("FAIL symbol: got cyc=%0d dibit=%b zero=%b, required cyc=%0d dibit=%b zero=%b",
                   cyc, sym_dibit, sym_zero, e.c, e.d, e.z);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_frame(input int s, input int slot0);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.c = s + 1 + 8 * k; e.d = (k % 2 == 1) ? 2'b11 : 2'b00; e.z = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      e.c = s + 33 + 8 * k; e.d = src_val[slot0 + k] ? src_dat[slot0 + k] : 2'b00; e.z = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 2; k++) begin
      e.c = s + 65 + 8 * k; e.d = 2'b00; e.z = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    n_cmp += 6;
    if (sym_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b, required 0", sym_strobe); end
    if (sym_dibit !== 2'b00) begin n_err++; $display("FAIL reset_dibit: got %b, required 00", sym_dibit); end
    if (sym_zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b, required 1", sym_zero); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b, required 0", underflow); end
    if (bit_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b, required 0", bit_ready); end
  endtask

  task automatic test_frame();
    int s, rel;
    logic exp_r, exp_b;
    src_dat[0] = 2'b01; src_dat[1] = 2'b10; src_dat[2] = 2'b11; src_dat[3] = 2'b00;
    for (int i = 0; i < 8; i++) src_val[i] = 1'b1;
    src_idx = 0;
    step(); step();
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 84; i++) begin
      rel = cyc - s;
      exp_r = (rel == 32 || rel == 40 || rel == 48 || rel == 56);
      exp_b = (rel <= 80);
      n_cmp += 3;
      if (bit_ready !== exp_r) begin n_err++; $display("FAIL frame_ready rel=%0d: got %b, required %b", rel, bit_ready, exp_r); end
      if (busy !== exp_b) begin n_err++; $display("FAIL frame_busy rel=%0d: got %b, required %b", rel, busy, exp_b); end
      if (underflow !== 1'b0) begin n_err++; $display("FAIL frame_underflow rel=%0d: got %b, required 0", rel, underflow); end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL frame_missing_symbols: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_underflow();
    int s, rel;
    logic exp_u, exp_b;
    src_dat[0] = 2'b11; src_dat[1] = 2'b01; src_dat[2] = 2'b10; src_dat[3] = 2'b11;
    src_val[0] = 1'b1;  src_val[1] = 1'b0;  src_val[2] = 1'b1;  src_val[3] = 1'b1;
    src_idx = 0;
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 84; i++) begin
      rel = cyc - s;
      exp_u = (rel >= 41);
      exp_b = (rel <= 80);
      n_cmp += 2;
      if (underflow !== exp_u) begin n_err++; $display("FAIL underflow_flag rel=%0d: got %b, required %b", rel, underflow, exp_u); end
      if (busy !== exp_b) begin n_err++; $display("FAIL underflow_busy rel=%0d: got %b, required %b", rel, busy, exp_b); end
      step();
    end
    src_val[1] = 1'b1;
    src_idx = 0;
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 84; i++) begin
      n_cmp++;
      if (underflow !== 1'b1) begin n_err++; $display("FAIL underflow_sticky rel=%0d: got %b, required 1", cyc - s, underflow); end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL underflow_missing_symbols: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_continuous();
    int s, rel;
    logic exp_r, exp_b;
    for (int i = 0; i < 8; i++) begin
      src_dat[i] = 2'($urandom_range(0, 3));
      src_val[i] = 1'b1;
    end
    src_idx = 0;
    cont = 1'b1;
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    push_frame(s + 80, 4);
    step();
    start = 1'b0;
    for (int i = 0; i < 164; i++) begin
      rel = cyc - s;
      if (rel == 100) cont = 1'b0;
      exp_r = (rel < 144) && ((rel % 80) == 32 || (rel % 80) == 40 || (rel % 80) == 48 || (rel % 80) == 56);
      exp_b = (rel <= 160);
      n_cmp += 3;
      if (bit_ready !== exp_r) begin n_err++; $display("FAIL cont_ready rel=%0d: got %b, required %b", rel, bit_ready, exp_r); end
      if (busy !== exp_b) begin n_err++; $display("FAIL cont_busy rel=%0d: got %b, required %b", rel, busy, exp_b); end
      if (underflow !== 1'b1) begin n_err++; $display("FAIL cont_underflow rel=%0d: got %b, required 1", rel, underflow); end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL cont_missing_symbols: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int s, rel;
    logic exp_b, exp_r;
    for (int i = 0; i < 8; i++) begin
      src_dat[i] = 2'($urandom_range(0, 3));
      src_val[i] = 1'b1;
    end
    src_idx = 0;
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    step();
    while (cyc - s < 35) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    src_idx = 0;
    n_cmp += 6;
    if (sym_strobe !== 1'b0) begin n_err++; $display("FAIL abort_strobe: got %b, required 0", sym_strobe); end
    if (sym_dibit !== 2'b00) begin n_err++; $display("FAIL abort_dibit: got %b, required 00", sym_dibit); end
    if (sym_zero !== 1'b1) begin n_err++; $display("FAIL abort_zero: got %b, required 1", sym_zero); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (underflow !== 1'b0) begin n_err++; $display("FAIL abort_underflow: got %b, required 0", underflow); end
    if (bit_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b, required 0", bit_ready); end
    s = cyc;
    start = 1'b1;
    push_frame(s, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 84; i++) begin
      rel = cyc - s;
      exp_r = (rel == 32 || rel == 40 || rel == 48 || rel == 56);
      exp_b = (rel <= 80);
      n_cmp += 2;
      if (busy !== exp_b) begin n_err++; $display("FAIL restart_busy rel=%0d: got %b, required %b", rel, busy, exp_b); end
      if (bit_ready !== exp_r) begin n_err++; $display("FAIL restart_ready rel=%0d: got %b, required %b", rel, bit_ready, exp_r); end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL restart_missing_symbols: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_small_frame();
    int s, rel;
    logic exp_s, exp_r, exp_b;
    logic [1:0] exp_d;
    logic exp_z;
    s = cyc;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rel = cyc - s;
      exp_s = (rel == 1 || rel == 3 || rel == 5);
      exp_r = (rel == 2 || rel == 4);
      exp_b = (rel <= 6);
      n_cmp += 3;
      if (sym_strobe2 !== exp_s) begin n_err++; $display("FAIL small_strobe rel=%0d: got %b, required %b", rel, sym_strobe2, exp_s); end
      if (bit_ready2 !== (rel == 2)) begin n_err++; $display("FAIL small_ready rel=%0d: got %b, required %b", rel, bit_ready2, exp_r && rel == 2); end
      if (busy2 !== exp_b) begin n_err++; $display("FAIL small_busy rel=%0d: got %b, required %b", rel, busy2, exp_b); end
      if (exp_s) begin
        exp_d = (rel == 3) ? 2'b10 : 2'b00;
        exp_z = (rel == 5);
        n_cmp++;
        if (sym_dibit2 !== exp_d || sym_zero2 !== exp_z) begin
          n_err++;
          $display("FAIL small_symbol rel=%0d: got dibit=%b zero=%b, required dibit=%b zero=%b",
                   rel, sym_dibit2, sym_zero2, exp_d, exp_z);
        end
      end
      step();
    end
    n_cmp++;
    if (underflow2 !== 1'b0) begin n_err++; $display("FAIL small_underflow: got %b, required 0", underflow2); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; bit_valid = 1'b0; bit_data = 2'b00; start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      src_dat[i] = 2'b00;
      src_val[i] = 1'b1;
    end
    test_reset();
    test_frame();
    test_underflow();
    test_continuous();
    test_reset_midframe();
    test_small_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
